// File: rtl/fp16_normalizer.sv
// Purpose : post-add normalizer for IEEE-754 binary16; turns a raw 12-bit adder mantissa into a packed result.
// Latency : out_valid rises 2 cycles after the accept edge, plus 1 cycle per left shift (12 cycles worst case).
// Backpr. : one operand in flight; in_ready is low until the result is taken with out_ready, and outputs hold until then.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid/in_ready             operand handshake (in_ready high only when idle)
//   in_sign, in_exp, in_mant      sign, biased exponent (0 treated as 1), raw mantissa (bit 11 carry, bit 10 hidden)
//   out_valid/out_ready           result handshake
//   out_result                    packed {sign, exp[4:0], frac[9:0]}
//   out_shift                     number of left shifts applied (0..10)
//   out_flags                     {ovf, denorm, zero, rshift}
`timescale 1ns/1ps
module fp16_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [11:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_shift,
  output logic [3:0]  out_flags
);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t      state, next_state;

  // Working operand
  logic        sign_q;
  logic [4:0]  exp_q;
  logic [11:0] mant_q;
  logic [3:0]  shift_q;
  logic        ovf_q, denorm_q, zero_q, rshift_q;

  // Derived datapath values
  logic [11:0] mant_shl;
  logic [4:0]  exp_dec;
  logic [5:0]  exp_inc;   // one extra bit so an increment past 31 is still seen as overflow
  logic [15:0] pack;

  assign mant_shl = {mant_q[10:0], 1'b0};
  assign exp_dec  = exp_q - 5'd1;
  assign exp_inc  = {1'b0, exp_q} + 6'd1;

  // Result packing; special cases take precedence over the normal layout.
  always_comb begin
    pack = {sign_q, exp_q, mant_q[9:0]};
    if (zero_q)
      pack = {sign_q, 15'b0};
    else if (ovf_q)
      pack = {sign_q, 5'h1F, 10'h000};
    else if (denorm_q)
      pack = {sign_q, 5'b0, mant_q[9:0]};
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (in_valid) next_state = CHECK;
      CHECK: begin
        // Zero, carry-out, already-normal or already at the minimum exponent all finish immediately.
        if (mant_q == 12'h000 || mant_q[11] || mant_q[10] || exp_q == 5'd1)
          next_state = DONE;
        else
          next_state = SHIFT;
      end
      SHIFT: if (mant_shl[10] || exp_dec == 5'd1) next_state = DONE;
      DONE:  if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state == IDLE);
  end

  // ---------------- Datapath and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      exp_q      <= 5'd0;
      mant_q     <= 12'h000;
      shift_q    <= 4'd0;
      ovf_q      <= 1'b0;
      denorm_q   <= 1'b0;
      zero_q     <= 1'b0;
      rshift_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_shift  <= 4'd0;
      out_flags  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_sign;
            exp_q    <= (in_exp == 5'd0) ? 5'd1 : in_exp;
            mant_q   <= in_mant;
            shift_q  <= 4'd0;
            ovf_q    <= 1'b0;
            denorm_q <= 1'b0;
            zero_q   <= 1'b0;
            rshift_q <= 1'b0;
          end
        end
        CHECK: begin
          if (mant_q == 12'h000) begin
            zero_q <= 1'b1;
          end else if (mant_q[11]) begin
            // Carry-out: one right shift, bit 0 is dropped.
            mant_q   <= {1'b0, mant_q[11:1]};
            exp_q    <= exp_inc[4:0];
            rshift_q <= 1'b1;
            if (exp_inc >= 6'd31) ovf_q <= 1'b1;
          end else if (!mant_q[10] && exp_q == 5'd1) begin
            denorm_q <= 1'b1;
          end
        end
        SHIFT: begin
          mant_q  <= mant_shl;
          exp_q   <= exp_dec;
          shift_q <= shift_q + 4'd1;
          // Hitting the minimum exponent without a leading one leaves a denormal.
          if (!mant_shl[10] && exp_dec == 5'd1) denorm_q <= 1'b1;
        end
        DONE: begin
          // First DONE cycle latches the result; afterwards it is held until taken.
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_result <= pack;
            out_shift  <= shift_q;
            out_flags  <= {ovf_q, denorm_q, zero_q, rshift_q};
          end else if (out_ready) begin
            out_valid  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_normalizer.sv
`timescale 1ns/1ps
module tb_fp16_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_shift;
  logic [3:0]  out_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  fp16_normalizer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_shift  (out_shift),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present one operand, wait for the result, check it, then take it.
  task automatic run_op(input string tag, input logic s, input logic [4:0] e, input logic [11:0] m,
                        input logic [15:0] er, input logic [3:0] es, input logic [3:0] ef, input int elat);
    int lat;
    chk({tag, "/idle_ready"}, 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(elat));
    chk({tag, "/result"},  32'(out_result), 32'(er));
    chk({tag, "/shift"},   32'(out_shift), 32'(es));
    chk({tag, "/flags"},   32'(out_flags), 32'(ef));
    chk({tag, "/busy"},    32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/released_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "/released_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] held_res;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 5'd0; in_mant = 12'h000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/in_ready",  32'(in_ready), 32'd1);
    chk("reset/result",    32'(out_result), 32'd0);
    chk("reset/shift",     32'(out_shift), 32'd0);
    chk("reset/flags",     32'(out_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //                sign  exp    mant      result    shift  flags    lat
    run_op("identity", 1'b0, 5'd15, 12'h400, 16'h3C00, 4'd0,  4'b0000, 2);
    run_op("rshift",   1'b0, 5'd15, 12'hC00, 16'h4200, 4'd0,  4'b0001, 2);
    run_op("ovf",      1'b0, 5'd30, 12'hC00, 16'h7C00, 4'd0,  4'b1001, 2);
    run_op("full10",   1'b0, 5'd20, 12'h001, 16'h2800, 4'd10, 4'b0000, 12);
    run_op("denorm",   1'b0, 5'd3,  12'h010, 16'h0040, 4'd2,  4'b0100, 4);
    run_op("zero",     1'b1, 5'd9,  12'h000, 16'h8000, 4'd0,  4'b0010, 2);
    run_op("neg_norm", 1'b1, 5'd15, 12'h7FF, 16'hBFFF, 4'd0,  4'b0000, 2);
    run_op("shift3",   1'b0, 5'd5,  12'h0FF, 16'h0BF8, 4'd3,  4'b0000, 5);
    run_op("exp0_den", 1'b0, 5'd0,  12'h200, 16'h0200, 4'd0,  4'b0100, 2);
    run_op("exp0_rsh", 1'b0, 5'd0,  12'hC00, 16'h0A00, 4'd0,  4'b0001, 2);

    // Backpressure: result held for 5 cycles while a competing operand is offered.
    in_sign = 1'b0; in_exp = 5'd5; in_mant = 12'h0FF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp/latency", 32'(lat), 32'd5);
    held_res = 16'h0BF8;
    in_sign = 1'b1; in_exp = 5'd15; in_mant = 12'h400; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp/valid_held", 32'(out_valid), 32'd1);
      chk("bp/result_held", 32'(out_result), 32'(held_res));
      chk("bp/shift_held", 32'(out_shift), 32'd3);
      chk("bp/in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp/released_vld", 32'(out_valid), 32'd0);
    chk("bp/released_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp/no_stray_accept", 32'(in_ready), 32'd1);

    // Reset during the 4th shift of the 12'h001 case.
    in_sign = 1'b0; in_exp = 5'd20; in_mant = 12'h001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid/in_ready",  32'(in_ready), 32'd1);
    chk("rst_mid/result",    32'(out_result), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid/no_partial", 32'(out_valid), 32'd0);
    run_op("after_rst", 1'b0, 5'd15, 12'h400, 16'h3C00, 4'd0, 4'b0000, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
